// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache port arbiter: default-width request/response
// structs, the arbiter state encoding and a wrap-around index helper.
package dcache_arb_pkg;

  localparam int DEF_DATA_LENGTH = 32;
  localparam int DEF_ADDR_LENGTH = 32;
  localparam int DEF_MASK_LENGTH = DEF_DATA_LENGTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                       rw;
    logic [DEF_ADDR_LENGTH-1:0] addr;
    logic [DEF_DATA_LENGTH-1:0] data;
    logic [DEF_MASK_LENGTH-1:0] wmask;
  } dcache_req_t;

  typedef struct packed {
    logic                       ready;
    logic [DEF_DATA_LENGTH-1:0] data;
  } dcache_res_t;

  function automatic int wrap_index(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/dcache_rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// the last-granted index, wrapping around to include the last index itself.
module dcache_rr_pick
  import dcache_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int ID_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [ID_W-1:0]      i_last,
  output logic                 o_found,
  output logic [ID_W-1:0]      o_idx
);

  int w_pos;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      w_pos = wrap_index(int'(i_last) + k, NUM_PORTS);
      if (i_req[w_pos]) begin
        o_found = 1'b1;
        o_idx   = ID_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Round-robin front end that serialises NUM_PORTS CPU requests onto the
// single dcache port and routes the completion back to the granted requester.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_LENGTH = 32,
  localparam int MASK_LENGTH = DATA_LENGTH / 8,
  localparam int ID_W        = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_valid,
  input  logic [NUM_PORTS-1:0]             req_rw,
  input  logic [NUM_PORTS*ADDR_LENGTH-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_LENGTH-1:0] req_data,
  input  logic [NUM_PORTS*MASK_LENGTH-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]             res_ready,
  output logic [DATA_LENGTH-1:0]           res_data,
  output logic                             cache_valid,
  output logic                             cache_rw,
  output logic [ADDR_LENGTH-1:0]           cache_addr,
  output logic [DATA_LENGTH-1:0]           cache_data,
  output logic [MASK_LENGTH-1:0]           cache_wmask,
  input  logic                             cache_ready,
  input  logic [DATA_LENGTH-1:0]           cache_rdata,
  output logic [ID_W-1:0]                  grant_id
);

  arb_state_t       r_state;
  logic [ID_W-1:0]  r_last;
  logic             w_found;
  logic [ID_W-1:0]  w_idx;

  dcache_rr_pick #(
    .NUM_PORTS (NUM_PORTS)
  ) u_pick (
    .i_req   (req_valid),
    .i_last  (r_last),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  // The completion pulse is raised on the same edge that leaves BUSY, so it
  // is visible during the RESP cycle; RESP only retires the grant pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= ID_W'(NUM_PORTS - 1);
      res_ready   <= '0;
      res_data    <= '0;
      cache_valid <= 1'b0;
      cache_rw    <= 1'b0;
      cache_addr  <= '0;
      cache_data  <= '0;
      cache_wmask <= '0;
      grant_id    <= '0;
    end else begin
      res_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            cache_rw    <= req_rw[w_idx];
            cache_addr  <= req_addr[int'(w_idx)*ADDR_LENGTH +: ADDR_LENGTH];
            cache_data  <= req_data[int'(w_idx)*DATA_LENGTH +: DATA_LENGTH];
            cache_wmask <= req_wmask[int'(w_idx)*MASK_LENGTH +: MASK_LENGTH];
            grant_id    <= w_idx;
            cache_valid <= 1'b1;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (cache_ready) begin
            res_data            <= cache_rdata;
            res_ready[grant_id] <= 1'b1;
            cache_valid         <= 1'b0;
            r_state             <= RESP;
          end
        end
        RESP: begin
          r_last  <= grant_id;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed self-checking bench for dcache_port_arbiter: a 2-port instance for
// most scenarios plus a 4-port instance for the wrap-around search.
module tb_dcache_port_arbiter;

  logic        clk;
  logic        rst_n;

  logic [1:0]  req2Valid;
  logic [1:0]  req2Rw;
  logic [63:0] req2Addr;
  logic [63:0] req2Data;
  logic [7:0]  req2Wmask;
  logic [1:0]  res2Ready;
  logic [31:0] res2Data;
  logic        cache2Valid;
  logic        cache2Rw;
  logic [31:0] cache2Addr;
  logic [31:0] cache2Data;
  logic [3:0]  cache2Wmask;
  logic        cache2Ready;
  logic [31:0] cache2Rdata;
  logic        grant2Id;

  logic [3:0]   req4Valid;
  logic [3:0]   req4Rw;
  logic [127:0] req4Addr;
  logic [127:0] req4Data;
  logic [15:0]  req4Wmask;
  logic [3:0]   res4Ready;
  logic [31:0]  res4Data;
  logic         cache4Valid;
  logic         cache4Rw;
  logic [31:0]  cache4Addr;
  logic [31:0]  cache4Data;
  logic [3:0]   cache4Wmask;
  logic         cache4Ready;
  logic [31:0]  cache4Rdata;
  logic [1:0]   grant4Id;

  int checkCount;
  int failCount;

  dcache_port_arbiter #(.NUM_PORTS(2), .DATA_LENGTH(32), .ADDR_LENGTH(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req2Valid), .req_rw(req2Rw), .req_addr(req2Addr),
    .req_data(req2Data), .req_wmask(req2Wmask),
    .res_ready(res2Ready), .res_data(res2Data),
    .cache_valid(cache2Valid), .cache_rw(cache2Rw), .cache_addr(cache2Addr),
    .cache_data(cache2Data), .cache_wmask(cache2Wmask),
    .cache_ready(cache2Ready), .cache_rdata(cache2Rdata),
    .grant_id(grant2Id)
  );

  dcache_port_arbiter #(.NUM_PORTS(4), .DATA_LENGTH(32), .ADDR_LENGTH(32)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req4Valid), .req_rw(req4Rw), .req_addr(req4Addr),
    .req_data(req4Data), .req_wmask(req4Wmask),
    .res_ready(res4Ready), .res_data(res4Data),
    .cache_valid(cache4Valid), .cache_rw(cache4Rw), .cache_addr(cache4Addr),
    .cache_data(cache4Data), .cache_wmask(cache4Wmask),
    .cache_ready(cache4Ready), .cache_rdata(cache4Rdata),
    .grant_id(grant4Id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic rw,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] wmask);
    req2Valid[port]          = valid;
    req2Rw[port]             = rw;
    req2Addr[port*32 +: 32]  = addr;
    req2Data[port*32 +: 32]  = data;
    req2Wmask[port*4 +: 4]   = wmask;
  endtask

  task automatic applyReset();
    rst_n       = 1'b0;
    req2Valid   = '0;
    cache2Ready = 1'b0;
    req4Valid   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n;
    int cyc;
    int prev;

    checkCount  = 0;
    failCount   = 0;
    req2Rw      = '0;
    req2Addr    = '0;
    req2Data    = '0;
    req2Wmask   = '0;
    cache2Rdata = '0;
    req4Rw      = '0;
    req4Addr    = '0;
    req4Data    = '0;
    req4Wmask   = '0;
    cache4Ready = 1'b1;
    cache4Rdata = 32'h0000_4444;

    // Reset values
    applyReset();
    checkOutput("rst_cache_valid", 64'(cache2Valid), 64'd0);
    checkOutput("rst_res_ready", 64'(res2Ready), 64'd0);
    checkOutput("rst_res_data", 64'(res2Data), 64'd0);
    checkOutput("rst_cache_addr", 64'(cache2Addr), 64'd0);
    checkOutput("rst_grant_id", 64'(grant2Id), 64'd0);

    // Single read on port 0, ready one cycle after cache_valid
    applyStimulus(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
    stepCycle();
    checkOutput("rd_cache_valid", 64'(cache2Valid), 64'd1);
    checkOutput("rd_cache_addr", 64'(cache2Addr), 64'h100);
    checkOutput("rd_cache_rw", 64'(cache2Rw), 64'd0);
    checkOutput("rd_grant_id", 64'(grant2Id), 64'd0);
    stepCycle();
    checkOutput("rd_busy_hold", 64'(cache2Valid), 64'd1);
    checkOutput("rd_no_early_res", 64'(res2Ready), 64'd0);
    cache2Ready = 1'b1;
    cache2Rdata = 32'hDEAD_BEEF;
    stepCycle();
    checkOutput("rd_res_ready", 64'(res2Ready), 64'b01);
    checkOutput("rd_res_data", 64'(res2Data), 64'hDEAD_BEEF);
    checkOutput("rd_valid_drop", 64'(cache2Valid), 64'd0);
    applyStimulus(0, 1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
    cache2Ready = 1'b0;
    stepCycle();
    checkOutput("rd_res_pulse_end", 64'(res2Ready), 64'd0);

    // Both ports requesting continuously with instant ready: 0,1,0,1 every 3 cycles
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
    cache2Ready = 1'b1;
    cache2Rdata = 32'h0000_0AAA;
    n = 0; cyc = 0; prev = 0;
    while (n < 4 && cyc < 30) begin
      stepCycle();
      cyc++;
      if (res2Ready != 2'b00) begin
        checkOutput("rr_res_ready", 64'(res2Ready), (n % 2 == 0) ? 64'b01 : 64'b10);
        checkOutput("rr_addr", 64'(cache2Addr), (n % 2 == 0) ? 64'h200 : 64'h300);
        if (n > 0) checkOutput("rr_spacing", 64'(cyc - prev), 64'd3);
        prev = cyc;
        n++;
        if (n == 4) req2Valid = 2'b00;
      end
    end
    checkOutput("rr_count", 64'(n), 64'd4);
    cache2Ready = 1'b0;
    stepCycle();

    // Port 1 write with a 5-cycle stall; fields hold through all 6 BUSY cycles
    applyReset();
    applyStimulus(1, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    cache2Rdata = 32'hCAFE_F00D;
    for (int b = 1; b <= 6; b++) begin
      stepCycle();
      checkOutput("wr_valid_hold", 64'(cache2Valid), 64'd1);
      checkOutput("wr_addr_hold", 64'(cache2Addr), 64'h40);
      checkOutput("wr_data_hold", 64'(cache2Data), 64'h1234_5678);
      checkOutput("wr_mask_hold", 64'(cache2Wmask), 64'b0011);
      checkOutput("wr_rw_hold", 64'(cache2Rw), 64'd1);
      checkOutput("wr_no_res", 64'(res2Ready), 64'd0);
      if (b == 6) cache2Ready = 1'b1;
    end
    stepCycle();
    checkOutput("wr_res_ready", 64'(res2Ready), 64'b10);
    checkOutput("wr_grant_id", 64'(grant2Id), 64'd1);
    applyStimulus(1, 1'b0, 1'b1, 32'h40, 32'h1234_5678, 4'b0011);
    cache2Ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("wr_single_pulse", 64'(res2Ready), 64'd0);
    end

    // 4-port instance, last=3 after reset, ports 1 and 2 valid: 1 then 2
    applyReset();
    req4Addr[32 +: 32] = 32'h0000_1111;
    req4Addr[64 +: 32] = 32'h0000_2222;
    req4Valid = 4'b0110;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 20) begin
      stepCycle();
      cyc++;
      if (res4Ready != 4'b0000) begin
        checkOutput("wrap_res_ready", 64'(res4Ready), (n == 0) ? 64'b0010 : 64'b0100);
        checkOutput("wrap_grant_id", 64'(grant4Id), (n == 0) ? 64'd1 : 64'd2);
        checkOutput("wrap_addr", 64'(cache4Addr), (n == 0) ? 64'h1111 : 64'h2222);
        n++;
        if (n == 2) req4Valid = 4'b0000;
      end
    end
    checkOutput("wrap_count", 64'(n), 64'd2);

    // Reset pulsed mid-BUSY aborts without a completion
    applyReset();
    applyStimulus(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
    stepCycle();
    checkOutput("abort_busy", 64'(cache2Valid), 64'd1);
    checkOutput("abort_grant1", 64'(grant2Id), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid_async", 64'(cache2Valid), 64'd0);
    checkOutput("abort_res_ready", 64'(res2Ready), 64'd0);
    applyStimulus(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("abort_regrant_id", 64'(grant2Id), 64'd0);
    checkOutput("abort_regrant_addr", 64'(cache2Addr), 64'h600);
    cache2Ready = 1'b1;
    cache2Rdata = 32'h5A5A_5A5A;
    stepCycle();
    checkOutput("abort_res_port0", 64'(res2Ready), 64'b01);
    checkOutput("abort_res_data", 64'(res2Data), 64'h5A5A_5A5A);
    req2Valid   = 2'b00;
    cache2Ready = 1'b0;
    stepCycle();

    // Stray cache_ready while idle is ignored
    cache2Ready = 1'b1;
    cache2Rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      stepCycle();
      checkOutput("stray_res_ready", 64'(res2Ready), 64'd0);
      checkOutput("stray_res_data", 64'(res2Data), 64'h5A5A_5A5A);
      checkOutput("stray_cache_valid", 64'(cache2Valid), 64'd0);
    end
    cache2Ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Multi-requester front end for the data cache.
- Accepts NUM_PORTS independent CPU-side requests using the same valid/ready protocol as the existing CPU memory unit to dcache interface.
- Arbitrates round-robin, forwards one request at a time to the single dcache port, and routes the read data and completion pulse back to the granted requester.
- Sits between the memory unit(s) and the dcache; generalises the single-channel interface in port count, data/address width and byte-mask width.

Parameters:
- NUM_PORTS, 2, number of requester channels (2..8).
- DATA_LENGTH, 32, word width in bits (multiple of 8).
- ADDR_LENGTH, 32, address width in bits.
- MASK_LENGTH, DATA_LENGTH/8, byte write-mask width (derived, not overridable).
- ID_W, $clog2(NUM_PORTS), grant index width (derived).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_PORTS  per-port start signal.
- req_rw  in  NUM_PORTS  per-port 0=read, 1=write.
- req_addr  in  NUM_PORTS*ADDR_LENGTH  per-port address; port i at [i*ADDR_LENGTH +: ADDR_LENGTH].
- req_data  in  NUM_PORTS*DATA_LENGTH  per-port write data.
- req_wmask  in  NUM_PORTS*MASK_LENGTH  per-port byte write mask.
- res_ready  out  NUM_PORTS  per-port one-cycle done pulse.
- res_data  out  DATA_LENGTH  read data; valid only with a res_ready bit.
- cache_valid  out  1  request to dcache.
- cache_rw  out  1  registered rw.
- cache_addr  out  ADDR_LENGTH  registered address.
- cache_data  out  DATA_LENGTH  registered write data.
- cache_wmask  out  MASK_LENGTH  registered mask.
- cache_ready  in  1  dcache done pulse.
- cache_rdata  in  DATA_LENGTH  dcache read data, valid with cache_ready.
- grant_id  out  ID_W  index of the currently or last granted port (debug).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all outputs 0; last-grant pointer=NUM_PORTS-1, so port 0 has first priority.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from (last+1) mod NUM_PORTS, with wrap-around.
  - Latch that port's rw/addr/data/wmask into cache_* registers and set grant_id=idx.
  - Set cache_valid=1 and move to BUSY.
  - If no req_valid is set, stay in IDLE.
- BUSY:
  - Hold cache_valid and all cache_* fields stable.
  - When cache_ready=1: capture cache_rdata into res_data, clear cache_valid, move to RESP.
  - cache_ready in the same cycle cache_valid first rises is legal.
- RESP:
  - res_ready[grant_id]=1 for exactly one cycle; all other bits 0.
  - Set last=grant_id and return to IDLE.
- Latency: valid sampled at edge T0 → cache_valid high in T1. With cache_ready in T1 → res_ready in T2. Next grant is issued at T3 at the earliest.
- cache_ready outside BUSY is ignored.
- res_data:
  - Holds its value until the next capture.
  - Write completions also capture cache_rdata; requesters ignore res_data for writes.
- Requester rules:
  - Fields must be held stable while valid=1 until its res_ready pulse.
  - A valid still high in the cycle after res_ready is treated as a new request.
  - Dropping valid before completion is illegal; the arbiter still completes the latched request.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 other transactions.
- Simultaneous requests are resolved by the round-robin order only; address overlap is not checked.
- Reset asserted mid-transaction aborts it: no res_ready is produced, and cache_valid drops asynchronously.

Decomposition:
- Shared package dcache_arb_pkg holds:
  - the parametrised req/res struct typedefs, with wmask sized DATA_LENGTH/8;
  - the arbiter state enum {IDLE, BUSY, RESP}.
- Sub-module dcache_rr_pick is combinational.
  - Inputs: req vector and last pointer.
  - Outputs: found flag and index.
  - Reusable by other round-robin arbiters.

Test Plan:
- Reset then port 0 read, addr 0x100; cache_ready one cycle after cache_valid with rdata 0xDEADBEEF → cache_addr=0x100, cache_rw=0, res_ready=01 for one cycle, res_data=0xDEADBEEF, grant_id=0.
- Ports 0 and 1 both valid continuously (NUM_PORTS=2), instant cache_ready → grants alternate 0,1,0,1 over 4 transactions; res_ready pulses every 3 cycles.
- Port 1 write, addr 0x40, data 0x12345678, wmask 4'b0011; cache stalls 5 cycles → cache_* fields stable for all 6 BUSY cycles; res_ready=10 exactly once after cache_ready.
- NUM_PORTS=4, last grant=3, ports 1 and 2 valid → port 1 granted first, then port 2 (wrap-around search).
- rst_n pulsed low during BUSY → cache_valid=0 and res_ready=0 immediately; after release the first grant goes to the lowest-index valid port.
- Stray cache_ready in IDLE with no requests → no res_ready, res_data unchanged, state stays IDLE.
